// File: rtl/fft_bin_streamer.sv
`default_nettype none
// ============================================================================
// fft_bin_streamer : double-buffered parallel-to-serial FFT bin streamer
// Revision 1.0 - initial release
// ============================================================================
module fft_bin_streamer #(
    parameter int N           = 32,
    parameter int W           = 8,
    parameter int BIT_REVERSE = 0
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [N*W-1:0]       Xk_vect_real,
    input  logic [N*W-1:0]       Xk_vect_imag,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    output logic [W-1:0]         bin_real,
    output logic [W-1:0]         bin_imag,
    output logic [$clog2(N)-1:0] bin_idx,
    output logic                 bin_last
);

    localparam int               LOG2N         = $clog2(N);
    localparam logic [LOG2N-1:0] FIRST_BEAT    = '0;
    localparam logic [LOG2N-1:0] LAST_BEAT     = LOG2N'(N - 1);
    localparam logic             FIRST_IS_LAST = (N == 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q;
    logic [N*W-1:0]   act_re_q;
    logic [N*W-1:0]   act_im_q;
    logic [N*W-1:0]   pend_re_q;
    logic [N*W-1:0]   pend_im_q;
    logic             pend_full_q;
    logic [LOG2N-1:0] beat_q;
    logic [LOG2N-1:0] beat_d;
    logic             valid_q;
    logic             last_q;
    logic [W-1:0]     real_q;
    logic [W-1:0]     imag_q;
    logic             w_frame_hs;
    logic             w_beat_hs;

    function automatic logic [LOG2N-1:0] lane_of(input logic [LOG2N-1:0] beat);
        logic [LOG2N-1:0] rev;
        for (int b = 0; b < LOG2N; b++) begin
            rev[b] = beat[LOG2N-1-b];
        end
        return (BIT_REVERSE != 0) ? rev : beat;
    endfunction

    // Lane 0 sits in the most significant W bits of the vector.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] vec,
                                          input logic [LOG2N-1:0] beat);
        return vec[(N - 1 - int'(lane_of(beat))) * W +: W];
    endfunction

    assign frame_ready = rst & ~pend_full_q;
    assign w_frame_hs  = frame_valid & frame_ready;
    assign w_beat_hs   = valid_q & bin_ready;
    assign beat_d      = beat_q + LOG2N'(1);

    always_ff @(posedge clk1) begin
        if (!rst) begin
            state_q     <= IDLE;
            pend_full_q <= 1'b0;
            beat_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            real_q      <= '0;
            imag_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_frame_hs) begin
                        act_re_q <= Xk_vect_real;
                        act_im_q <= Xk_vect_imag;
                        state_q  <= STREAM;
                        valid_q  <= 1'b1;
                        beat_q   <= FIRST_BEAT;
                        last_q   <= FIRST_IS_LAST;
                        real_q   <= pick(Xk_vect_real, FIRST_BEAT);
                        imag_q   <= pick(Xk_vect_imag, FIRST_BEAT);
                    end
                end
                STREAM: begin
                    if (w_frame_hs && !(w_beat_hs && last_q)) begin
                        pend_re_q   <= Xk_vect_real;
                        pend_im_q   <= Xk_vect_imag;
                        pend_full_q <= 1'b1;
                    end
                    if (w_beat_hs) begin
                        if (!last_q) begin
                            beat_q <= beat_d;
                            last_q <= (beat_d == LAST_BEAT);
                            real_q <= pick(act_re_q, beat_d);
                            imag_q <= pick(act_im_q, beat_d);
                        end else if (pend_full_q) begin
                            act_re_q    <= pend_re_q;
                            act_im_q    <= pend_im_q;
                            pend_full_q <= 1'b0;
                            beat_q      <= FIRST_BEAT;
                            last_q      <= FIRST_IS_LAST;
                            real_q      <= pick(pend_re_q, FIRST_BEAT);
                            imag_q      <= pick(pend_im_q, FIRST_BEAT);
                        end else if (w_frame_hs) begin
                            // Frame offered on the last beat with nothing pending: chain it directly.
                            act_re_q <= Xk_vect_real;
                            act_im_q <= Xk_vect_imag;
                            beat_q   <= FIRST_BEAT;
                            last_q   <= FIRST_IS_LAST;
                            real_q   <= pick(Xk_vect_real, FIRST_BEAT);
                            imag_q   <= pick(Xk_vect_imag, FIRST_BEAT);
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            beat_q  <= FIRST_BEAT;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bin_valid = valid_q;
    assign bin_real  = real_q;
    assign bin_imag  = imag_q;
    assign bin_idx   = beat_q;
    assign bin_last  = last_q;

endmodule
`default_nettype wire

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
- Reads the parallel 32-bin spectrum presented by the FFT core on Xk_vect_real/Xk_vect_imag and streams it out one bin per clock over a valid/ready interface.
- Double-buffered, so the FFT can hand over the next frame while the current one is still draining.
- Sits between the FFT output and serial downstream consumers (magnitude, UART/DMA packer).

Parameters:
- N, 32: bins per frame; must be a power of 2.
- W, 8: bits per real or imaginary component.
- BIT_REVERSE, 0: 0 selects natural bin order; 1 emits lane bitrev(i) on beat i.

Ports:
- clk1  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on clk1.
- frame_valid  in  1  Xk vectors hold a complete frame.
- frame_ready  out  1  block can accept a frame.
- Xk_vect_real  in  N*W  real parts; lane k = bits [N*W-1-k*W -: W], so bin 0 is the MS byte.
- Xk_vect_imag  in  N*W  imaginary parts; same lane mapping.
- bin_valid  out  1  bin_real/bin_imag/bin_idx/bin_last are valid.
- bin_ready  in  1  downstream accepts the beat.
- bin_real  out  W  real part of the current bin.
- bin_imag  out  W  imaginary part of the current bin.
- bin_idx  out  log2(N)  beat number within the frame, 0..N-1.
- bin_last  out  1  high on beat N-1 only.

Behaviour:
- Storage:
  - Active buffer (real+imag, 2*N*W bits) is the frame being streamed.
  - Pending buffer (same size) plus a pending_full flag holds the next frame.
- Reset (rst low at a clk1 edge):
  - bin_valid=0, bin_last=0, bin_real=0, bin_imag=0, bin_idx=0.
  - pending_full=0; beat counter=0; state=IDLE.
  - frame_ready=0 while rst is low.
- frame_ready = rst & ~pending_full (combinational). A frame handshake is frame_valid & frame_ready at a clk1 edge.
- State IDLE (bin_valid=0):
  - On a frame handshake, the frame loads directly into the active buffer and the state goes to STREAM.
  - bin_valid rises on the next edge with beat 0 (latency 1 cycle), so pending stays empty.
- State STREAM:
  - Beat i presents lane L, where L = i (BIT_REVERSE=0) or L = bit-reverse of i over log2(N) bits (BIT_REVERSE=1). bin_idx = i.
  - A beat handshake is bin_valid & bin_ready. It advances i. Outputs are registered.
  - While bin_ready=0, all bin_* outputs hold stable.
  - A frame handshake during STREAM writes the pending buffer and sets pending_full.
- End of frame (handshake with bin_last=1):
  - pending_full=1: the pending buffer copies to active, pending_full clears, i=0, and beat 0 of the new frame is presented on the next edge. There is no bubble and bin_valid stays 1.
  - pending_full=0: go to IDLE and bin_valid drops on the next edge.
- Simultaneous events:
  - A frame handshake cannot coincide with a pending-to-active transfer, because frame_ready=0 while pending_full=1.
  - In IDLE, a frame handshake in the same cycle as reset release is impossible, because frame_ready=0 during reset.
- Input capture: Xk vectors are sampled only on the handshake edge. Later changes to the inputs do not affect stored frames.
- Reset mid-frame: the frame in progress and any pending frame are discarded. Outputs take their reset values on that edge. Streaming resumes only after a new frame handshake.
- Counter wrap: i runs 0..N-1; bin_last = (i==N-1). The counter returns to 0 after the last beat and is never allowed to overrun.
- Data is passed through unchanged (two's complement, no scaling).

Test Plan:
- Reset, then frame_valid=1 with real=0x00..00 and imag=0x00..00, bin_ready=1 -> frame_ready=1 after reset; bin_valid rises 1 cycle after the handshake; 32 beats of real=0x00, imag=0x00; bin_idx 0..31; bin_last only on idx 31; then bin_valid=0.
- Real lanes = 0x00,0x01..0x1F (MS byte = 0x00), imag lanes = 0xFF..0xE0, BIT_REVERSE=0 -> beat i gives bin_real=i, bin_imag=0xFF-i.
- Same frame with BIT_REVERSE=1 -> beats 0..3 give bin_real 0x00,0x10,0x08,0x18 while bin_idx reads 0,1,2,3.
- Two frames offered back-to-back with bin_ready=1 -> second accepted during streaming; frame_ready=0 until the first frame's last beat; 64 contiguous valid beats, idx wraps 31->0 with no bubble.
- Toggle bin_ready in the pattern 1,0,0,1 -> outputs frozen on stalled cycles; no beat lost or duplicated; all 32 beats in order.
- Assert rst low at beat 10 with a pending frame held -> next edge: bin_valid=0, bin_idx=0, frame_ready=0; after release, no output until a new frame handshake.
